// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch / PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF    = 16;
    localparam int unsigned INSTR_W_DEF = 9;
    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RESOLVE,
        HALT
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-PC mux: hold, increment with wrap, or take the branch target.
module pc_next
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_target,
    input  logic            in_resolve,
    input  logic            advance,
    input  logic            compres,
    output logic [PC_W-1:0] pc_nxt_c
);

    logic [PC_W-1:0] pc_inc;

    // Increment is naturally modulo 2^PC_W; the target is used verbatim.
    assign pc_inc = pc + PC_W'(1);

    always_comb begin
        pc_nxt_c = pc;
        if (in_resolve) begin
            pc_nxt_c = compres ? branch_target : pc_inc;
        end else if (advance) begin
            pc_nxt_c = pc_inc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch and PC sequencer: fetch, issue with valid/ready, resolve branches, halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               is_branch,
    input  logic               halt,
    input  logic               compres,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
    output logic               branch_taken,
    output logic               halted,
    output logic [15:0]        retired
);

    seq_state_t      state;
    logic            in_resolve;
    logic            advance;
    logic [PC_W-1:0] pc_nxt_c;

    assign in_resolve = (state == RESOLVE);
    assign advance    = (state == ISSUE) && instr_ready && !halt && !is_branch;
    assign imem_addr  = pc;

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc            (pc),
        .branch_target (branch_target),
        .in_resolve    (in_resolve),
        .advance       (advance),
        .compres       (compres),
        .pc_nxt_c      (pc_nxt_c)
    );

    // Sequencer FSM; strobes are registered alongside the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= START_PC;
            instr        <= '0;
            retired      <= '0;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
            halted       <= 1'b0;
        end else begin
            pc           <= pc_nxt_c;
            branch_taken <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_data;
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        if (retired != RETIRED_MAX) begin
                            retired <= retired + 16'd1;
                        end
                        instr_valid <= 1'b0;
                        // Halt wins over branch when both flags are set.
                        if (halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (is_branch) begin
                            state <= RESOLVE;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                RESOLVE: begin
                    branch_taken <= compres;
                    state        <= FETCH;
                    imem_req     <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a transaction-level model.
module tb_pc_sequencer;

    localparam logic [15:0] START = 16'h0010;

    localparam int M_IDLE    = 0;
    localparam int M_FETCH   = 1;
    localparam int M_ISSUE   = 2;
    localparam int M_RESOLVE = 3;
    localparam int M_HALT    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_valid = 1'b0;
    logic [8:0]  imem_data = '0;
    logic        instr_ready = 1'b0;
    logic        is_branch = 1'b0;
    logic        halt = 1'b0;
    logic        compres = 1'b0;
    logic [15:0] branch_target = '0;

    logic [15:0] imem_addr;
    logic        imem_req;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        branch_taken;
    logic        halted;
    logic [15:0] retired;

    always #5 clock = ~clock;

    pc_sequencer #(
        .PC_W     (16),
        .INSTR_W  (9),
        .START_PC (START)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .is_branch     (is_branch),
        .halt          (halt),
        .compres       (compres),
        .branch_target (branch_target),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .halted        (halted),
        .retired       (retired)
    );

    // Program image; bit 8 marks halt, bit 7 marks branch for the bench decoder.
    logic [8:0]  prog [0:65535];

    int          vectors = 0;
    int          miscompares = 0;

    bit          rnd_mode = 1'b0;
    int          mem_delay = 0;
    int          rdy_delay = 0;
    int          wcnt = 0;
    int          rcnt = 0;
    logic        br_compres = 1'b0;
    logic [15:0] br_target = '0;

    int          m_mode = M_IDLE;
    int          m_pc = 0;
    int          m_count = 0;
    int          ret_bias = 0;
    logic [8:0]  m_instr = '0;
    bit          m_taken = 1'b0;
    bit          m_init = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model advanced once per rising edge from the sampled inputs.
    function automatic void model_update();
        m_taken = 1'b0;
        if (reset) begin
            m_mode   = M_IDLE;
            m_pc     = int'(START);
            m_instr  = '0;
            m_count  = 0;
            ret_bias = 0;
            m_init   = 1'b1;
            return;
        end
        if (!m_init) return;
        case (m_mode)
            M_IDLE:  m_mode = M_FETCH;
            M_FETCH: begin
                if (imem_valid) begin
                    m_instr = imem_data;
                    m_mode  = M_ISSUE;
                end
            end
            M_ISSUE: begin
                if (instr_ready) begin
                    m_count++;
                    if (halt) m_mode = M_HALT;
                    else if (is_branch) m_mode = M_RESOLVE;
                    else begin
                        m_pc   = (m_pc + 1) % 65536;
                        m_mode = M_FETCH;
                    end
                end
            end
            M_RESOLVE: begin
                if (compres) begin
                    m_pc    = int'(branch_target);
                    m_taken = 1'b1;
                end else begin
                    m_pc = (m_pc + 1) % 65536;
                end
                m_mode = M_FETCH;
            end
            default: ;
        endcase
    endfunction

    task automatic compare();
        int exp_ret;
        if (!m_init) return;
        exp_ret = m_count + ret_bias;
        if (exp_ret > 65535) exp_ret = 65535;
        check("pc",           32'(pc),           32'(m_pc));
        check("imem_addr",    32'(imem_addr),    32'(m_pc));
        check("imem_req",     32'(imem_req),     32'(m_mode == M_FETCH));
        check("instr_valid",  32'(instr_valid),  32'(m_mode == M_ISSUE));
        check("halted",       32'(halted),       32'(m_mode == M_HALT));
        check("instr",        32'(instr),        32'(m_instr));
        check("retired",      32'(retired),      32'(exp_ret));
        check("branch_taken", 32'(branch_taken), 32'(m_taken));
    endtask

    // Memory and decoder responders, reacting to the registered DUT outputs.
    task automatic drive();
        if (imem_req) begin
            if (rnd_mode) begin
                imem_valid = ($urandom_range(0, 2) == 0);
            end else if (wcnt < mem_delay) begin
                wcnt++;
                imem_valid = 1'b0;
            end else begin
                imem_valid = 1'b1;
            end
            imem_data = prog[imem_addr];
        end else begin
            wcnt       = 0;
            imem_valid = 1'($urandom_range(0, 1));
            imem_data  = 9'($urandom);
        end
        if (instr_valid) begin
            if (rnd_mode) begin
                instr_ready = 1'($urandom_range(0, 1));
            end else if (rcnt < rdy_delay) begin
                rcnt++;
                instr_ready = 1'b0;
            end else begin
                instr_ready = 1'b1;
            end
            halt      = instr[8];
            is_branch = instr[7];
        end else begin
            rcnt        = 0;
            instr_ready = 1'($urandom_range(0, 1));
            halt        = 1'($urandom_range(0, 1));
            is_branch   = 1'($urandom_range(0, 1));
        end
        if (rnd_mode) begin
            compres       = 1'($urandom_range(0, 1));
            branch_target = 16'($urandom);
        end else begin
            compres       = br_compres;
            branch_target = br_target;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        drive();
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic init_plain();
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = 16'(i);
            prog[i] = {2'b00, a[6:0]};
        end
    endtask

    // Advance until imem_req rises; report address, cycles taken and branch pulses seen.
    task automatic next_fetch(output logic [15:0] a, output int cyc, output int taken);
        logic prev;
        prev  = imem_req;
        a     = '0;
        cyc   = 0;
        taken = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cyc++;
            if (branch_taken) taken++;
            if (imem_req && !prev) begin
                a = imem_addr;
                return;
            end
            prev = imem_req;
        end
        vectors++;
        miscompares++;
        $display("FAIL fetch_timeout: no imem_req rise within 100 cycles at %0t", $time);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          c;
        int          t;
        int          n;
        int          bad;

        init_plain();
        do_reset();
        check("rst_pc",          32'(pc),           32'h0010);
        check("rst_imem_addr",   32'(imem_addr),    32'h0010);
        check("rst_instr",       32'(instr),        32'h0);
        check("rst_retired",     32'(retired),      32'h0);
        check("rst_req",         32'(imem_req),     32'h0);
        check("rst_valid",       32'(instr_valid),  32'h0);
        check("rst_taken",       32'(branch_taken), 32'h0);
        check("rst_halted",      32'(halted),       32'h0);

        // Straight-line code, zero wait states.
        prog[16'h0013] = 9'h100;
        next_fetch(a, c, t);
        check("first_fetch_addr", 32'(a), 32'h0010);
        check("first_fetch_cyc",  32'(c), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            next_fetch(a, c, t);
            check("seq_addr", 32'(a), 32'(16'h0010 + 16'(k)));
            check("seq_cyc",  32'(c), 32'd2);
        end
        check("seq_retired", 32'(retired), 32'd3);
        init_plain();

        // Taken branch 0x10 -> 0x20, then taken branch 0x20 -> 0x05.
        prog[16'h0010] = 9'h080;
        prog[16'h0020] = 9'h080;
        prog[16'h0005] = 9'h100;
        prog[16'h0021] = 9'h100;
        br_compres = 1'b1;
        br_target  = 16'h0020;
        do_reset();
        next_fetch(a, c, t);
        next_fetch(a, c, t);
        check("br1_addr", 32'(a), 32'h0020);
        br_target = 16'h0005;
        next_fetch(a, c, t);
        check("br_taken_addr",  32'(a), 32'h0005);
        check("br_taken_cyc",   32'(c), 32'd3);
        check("br_taken_count", 32'(t), 32'd1);
        step();
        check("br_taken_once",  32'(branch_taken), 32'h0);

        // Not-taken branch at 0x20 falls through to 0x21.
        br_compres = 1'b1;
        br_target  = 16'h0020;
        do_reset();
        next_fetch(a, c, t);
        next_fetch(a, c, t);
        br_compres = 1'b0;
        next_fetch(a, c, t);
        check("br_nt_addr",  32'(a), 32'h0021);
        check("br_nt_cyc",   32'(c), 32'd3);
        check("br_nt_count", 32'(t), 32'd0);
        init_plain();

        // Slow memory and slow decoder.
        prog[16'h0010] = 9'h055;
        prog[16'h0011] = 9'h100;
        mem_delay = 4;
        rdy_delay = 3;
        do_reset();
        next_fetch(a, c, t);
        n = 0;
        while (imem_req && n < 50) begin
            n++;
            step();
        end
        check("slow_req_cycles", 32'(n), 32'd5);
        n = 0;
        while (instr_valid && n < 50) begin
            n++;
            check("slow_instr_stable", 32'(instr), 32'h055);
            step();
        end
        check("slow_valid_cycles", 32'(n), 32'd4);
        mem_delay = 0;
        init_plain();

        // PC wrap at 0xFFFF and retired-count saturation.
        prog[16'h0010] = 9'h080;
        prog[16'h0000] = 9'h100;
        br_compres = 1'b1;
        br_target  = 16'hFFFF;
        do_reset();
        next_fetch(a, c, t);
        next_fetch(a, c, t);
        check("wrap_pre_addr", 32'(a), 32'hFFFF);
        n = 0;
        while (!instr_valid && n < 20) begin
            n++;
            step();
        end
        force dut.retired = 16'hFFFF;
        ret_bias = 65535 - m_count;
        #1;
        release dut.retired;
        next_fetch(a, c, t);
        check("wrap_addr",     32'(a),       32'h0000);
        check("sat_retired",   32'(retired), 32'hFFFF);
        rdy_delay = 0;
        init_plain();

        // Halt and branch together: halt wins and the sequencer goes quiet.
        prog[16'h0010] = 9'h180;
        br_compres = 1'b1;
        br_target  = 16'h0005;
        do_reset();
        next_fetch(a, c, t);
        n = 0;
        while (!halted && n < 20) begin
            n++;
            step();
        end
        check("halt_cyc",    32'(n),      32'd2);
        check("halt_flag",   32'(halted), 32'h1);
        check("halt_pc",     32'(pc),     32'h0010);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req || instr_valid || branch_taken || pc != 16'h0010) bad++;
        end
        check("halt_quiet", 32'(bad), 32'd0);
        init_plain();

        // Reset while a fetch is stalled; a late imem_valid must be ignored.
        prog[16'h0010] = 9'h033;
        mem_delay = 10;
        do_reset();
        next_fetch(a, c, t);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 9'h1FF;
        check("rr_idle_req",   32'(imem_req), 32'h0);
        check("rr_idle_pc",    32'(pc),       32'h0010);
        check("rr_idle_instr", 32'(instr),    32'h0);
        mem_delay = 0;
        step();
        check("rr_req",        32'(imem_req),  32'h1);
        check("rr_addr",       32'(imem_addr), 32'h0010);
        check("rr_instr_kept", 32'(instr),     32'h0);
        step();
        check("rr_valid",      32'(instr_valid), 32'h1);
        check("rr_instr",      32'(instr),       32'h033);

        // Random traffic: random memory/decoder waits, branches, targets and halts.
        for (int i = 0; i < 65536; i++) begin
            int unsigned r;
            logic [8:0]  w;
            r    = $urandom_range(0, 63);
            w    = 9'($urandom);
            w[8] = (r == 0);
            w[7] = (r >= 1 && r < 17);
            prog[i] = w;
        end
        rnd_mode = 1'b1;
        for (int seg = 0; seg < 15; seg++) begin
            do_reset();
            repeat (250) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and program-counter sequencer feeding the decoder and ALU. It fetches one instruction at a time from instruction memory and issues it downstream with a valid/ready handshake. For branch instructions it consumes the ALU's compare result (`compres`) and target (`out`) to choose the next PC. It also tracks halt and a retired-instruction count.

## Interface
Parameters:
- `PC_W`, 16, PC and branch-target width
- `INSTR_W`, 9, instruction word width
- `START_PC`, 0, PC value loaded on reset

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_addr`  out  PC_W  fetch address, always equal to `pc`
- `imem_req`  out  1  fetch request, high only in FETCH
- `imem_valid`  in  1  `imem_data` is valid this cycle
- `imem_data`  in  INSTR_W  fetched instruction
- `instr`  out  INSTR_W  held instruction to the decoder
- `instr_valid`  out  1  `instr` is offered, high only in ISSUE
- `instr_ready`  in  1  decoder accepts `instr`
- `is_branch`  in  1  decoder flag: the offered instruction is a branch
- `halt`  in  1  decoder flag: the offered instruction is halt
- `compres`  in  1  ALU branch-condition result
- `branch_target`  in  PC_W  ALU `out` (branch destination)
- `pc`  out  PC_W  current PC
- `branch_taken`  out  1  one-cycle pulse when a branch redirects the PC
- `halted`  out  1  sequencer is in HALT
- `retired`  out  16  count of accepted instructions, saturating

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE, HALT.
- IDLE: entered on reset. Lasts exactly one cycle, then goes to FETCH.
- FETCH: `imem_req`=1.
  - On `imem_valid`: capture `imem_data` into `instr`, go to ISSUE.
  - Otherwise stay in FETCH. There is no timeout.
- ISSUE: `instr_valid`=1. `instr` is held stable until `instr_ready`. On `instr_ready`, `retired` increments, then with priority:
  - `halt`: go to HALT, PC unchanged. Halt beats branch.
  - `is_branch`: go to RESOLVE, PC unchanged.
  - Otherwise: `pc`←`pc`+1, go to FETCH.
- RESOLVE: lasts one cycle. The ALU has settled on the decoded branch operands.
  - If `compres`=1: `pc`←`branch_target`, and `branch_taken` pulses for this cycle.
  - Else: `pc`←`pc`+1.
  - Go to FETCH.
- HALT: absorbing state. `halted`=1, `imem_req`=0, `instr_valid`=0. Only `reset` leaves it.
- Arithmetic:
  - `pc`+1 is modulo 2^PC_W, so 0xFFFF→0x0000 with no flag.
  - `branch_target` is taken verbatim, with no alignment check.
  - `retired` saturates at 0xFFFF.
- Ignored inputs:
  - `imem_valid` outside FETCH.
  - `compres` and `branch_target` outside RESOLVE.
  - `halt` and `is_branch` when `instr_valid`=0 or `instr_ready`=0.

## Timing
- Reset values:
  - `pc`=`imem_addr`=START_PC
  - `instr`=0, `retired`=0
  - `imem_req`=0, `instr_valid`=0, `branch_taken`=0, `halted`=0
  - state=IDLE
- Reset mid-operation: any state returns to IDLE on the next edge. An in-flight fetch is abandoned and a late `imem_valid` is ignored.
- All outputs are registered or decoded from state only. There are no combinational input→output paths.
- Minimum latency with zero memory and decoder wait:
  - Non-branch: FETCH→ISSUE→FETCH, 2 cycles per instruction.
  - Branch: FETCH→ISSUE→RESOLVE→FETCH, 3 cycles.
  - After reset, the first `imem_req` rises in cycle 2 (cycle 1 is IDLE).
- `imem_valid` arriving in the same cycle that `imem_req` rises is accepted.

## Structure
- Shared package (e.g. `cpu_pkg`) holds:
  - the state enum `seq_state_t` (IDLE, FETCH, ISSUE, RESOLVE, HALT);
  - constants `PC_W_DEF`=16 and `INSTR_W_DEF`=9;
  - `RETIRED_MAX`=16'hFFFF.
- One sub-module is natural: `pc_next`, a combinational next-PC mux (hold / +1 wrap / `branch_target`) selected by state and `compres`. All registers stay in `pc_sequencer`.

## Test plan
- Reset with START_PC=0x0010, memory answering in the same cycle, ready tied high, three non-branch instructions → `imem_addr` sequence 0x10, 0x11, 0x12, one instruction every 2 cycles, `retired`=3.
- Branch at 0x0020 with `compres`=1 and `branch_target`=0x0005 → `branch_taken` pulses once in RESOLVE and the next fetch is at 0x0005. Repeat with `compres`=0 → next fetch is at 0x0021 and no pulse.
- Memory delays `imem_valid` by 4 cycles and the decoder holds `instr_ready` low for 3 cycles → `imem_req` stays high for 5 cycles, and `instr` stays stable while `instr_valid` is high.
- `pc`=0xFFFF with a non-branch instruction → next `imem_addr`=0x0000. Separately, force `retired`=0xFFFF and accept one more instruction → it stays 0xFFFF.
- `halt` and `is_branch` both asserted at acceptance → `halted`=1, `pc` unchanged, no RESOLVE entered, and no further `imem_req` for 20 cycles.
- `reset` asserted in FETCH while the memory is stalled, with `imem_valid` pulsing the next cycle → the state is IDLE, the pulse is ignored, and the fetch restarts at START_PC.
